// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV32 pipeline: formats loads/stores onto a req/ack
// data-memory port, stalls upstream while an access is outstanding, and registers WB results.
module mem_access_stage #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] rs2_data_mem,
   input  logic [4:0]  rd_mem,
   input  logic [31:0] pc_p_4_mem,
   input  logic        mem_read_mem,
   input  logic        mem_write_mem,
   input  logic [2:0]  funct3_mem,
   input  logic        reg_write_mem,
   input  logic [1:0]  wb_sel_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] wb_data_wb,
   output logic [4:0]  rd_wb,
   output logic        reg_write_wb,
   output logic        valid_wb,
   output logic        access_fault,
   output logic        timeout_fault
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [15:0] LAST_WAIT = 16'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  rd_q, rd_d;
   logic        rw_q, rw_d;
   logic [1:0]  wb_sel_q, wb_sel_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [4:0]  rd_wb_q, rd_wb_d;
   logic        reg_write_wb_q, reg_write_wb_d;
   logic        valid_wb_q, valid_wb_d;
   logic        access_fault_q, access_fault_d;
   logic        timeout_fault_q, timeout_fault_d;

   logic        is_mem, bad_access, timeout_hit;
   logic [1:0]  off;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;

   assign off    = alu_result_mem[1:0];
   assign is_mem = valid_mem & (mem_read_mem | mem_write_mem);

   always_comb begin
      bad_access = 1'b0;
      if (funct3_mem == 3'b011 || funct3_mem == 3'b110 || funct3_mem == 3'b111)
         bad_access = 1'b1;
      else if (funct3_mem[1:0] == 2'b01 && off[0])
         bad_access = 1'b1;
      else if (funct3_mem == 3'b010 && off != 2'b00)
         bad_access = 1'b1;
   end

   // Byte and half stores replicate the data across all lanes; be picks the lane.
   always_comb begin
      case (funct3_mem[1:0])
         2'b00: begin
            be_fmt    = 4'b0001 << off;
            wdata_fmt = {4{rs2_data_mem[7:0]}};
         end
         2'b01: begin
            be_fmt    = off[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{rs2_data_mem[15:0]}};
         end
         default: begin
            be_fmt    = 4'b1111;
            wdata_fmt = rs2_data_mem;
         end
      endcase
   end

   always_comb begin
      ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
      ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_val = {24'h0, ld_byte};
         3'b101:  ld_val = {16'h0, ld_half};
         default: ld_val = dmem_rdata;
      endcase
   end

   // An ack in the last allowed cycle wins over the timeout.
   assign timeout_hit = (state_q == S_BUSY) && !dmem_ack && (cnt_q == LAST_WAIT);

   assign stall = rst_n & (((state_q == S_IDLE) & is_mem & ~bad_access) |
                           ((state_q == S_BUSY) & ~dmem_ack & ~timeout_hit));

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      dmem_req_d      = dmem_req_q;
      dmem_we_d       = dmem_we_q;
      dmem_addr_d     = dmem_addr_q;
      dmem_wdata_d    = dmem_wdata_q;
      dmem_be_d       = dmem_be_q;
      f3_d            = f3_q;
      off_d           = off_q;
      rd_d            = rd_q;
      rw_d            = rw_q;
      wb_sel_d        = wb_sel_q;
      alu_d           = alu_q;
      pc4_d           = pc4_q;
      wb_data_d       = wb_data_q;
      rd_wb_d         = rd_wb_q;
      reg_write_wb_d  = reg_write_wb_q;
      valid_wb_d      = valid_wb_q;
      access_fault_d  = 1'b0;
      timeout_fault_d = timeout_fault_q;
      case (state_q)
         S_IDLE: begin
            if (is_mem && !bad_access) begin
               state_d        = S_BUSY;
               cnt_d          = 16'd0;
               dmem_req_d     = 1'b1;
               dmem_we_d      = mem_write_mem;
               dmem_addr_d    = {alu_result_mem[31:2], 2'b00};
               dmem_wdata_d   = wdata_fmt;
               dmem_be_d      = be_fmt;
               f3_d           = funct3_mem;
               off_d          = off;
               rd_d           = rd_mem;
               rw_d           = reg_write_mem;
               wb_sel_d       = wb_sel_mem;
               alu_d          = alu_result_mem;
               pc4_d          = pc_p_4_mem;
               valid_wb_d     = 1'b0;
               reg_write_wb_d = 1'b0;
            end else if (is_mem) begin
               access_fault_d = 1'b1;
               valid_wb_d     = 1'b0;
               reg_write_wb_d = 1'b0;
            end else begin
               wb_data_d      = (wb_sel_mem == 2'b10) ? pc_p_4_mem : alu_result_mem;
               rd_wb_d        = rd_mem;
               reg_write_wb_d = reg_write_mem & valid_mem;
               valid_wb_d     = valid_mem;
            end
         end
         S_BUSY: begin
            if (dmem_ack) begin
               state_d        = S_IDLE;
               dmem_req_d     = 1'b0;
               wb_data_d      = dmem_we_q ? ((wb_sel_q == 2'b10) ? pc4_q : alu_q) : ld_val;
               rd_wb_d        = rd_q;
               reg_write_wb_d = rw_q;
               valid_wb_d     = 1'b1;
            end else if (timeout_hit) begin
               state_d         = S_IDLE;
               dmem_req_d      = 1'b0;
               valid_wb_d      = 1'b0;
               reg_write_wb_d  = 1'b0;
               timeout_fault_d = 1'b1;
            end else begin
               cnt_d          = cnt_q + 16'd1;
               valid_wb_d     = 1'b0;
               reg_write_wb_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= 16'd0;
         dmem_req_q      <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= 32'h0;
         dmem_wdata_q    <= 32'h0;
         dmem_be_q       <= 4'h0;
         f3_q            <= 3'b000;
         off_q           <= 2'b00;
         rd_q            <= 5'd0;
         rw_q            <= 1'b0;
         wb_sel_q        <= 2'b00;
         alu_q           <= 32'h0;
         pc4_q           <= 32'h0;
         wb_data_q       <= 32'h0;
         rd_wb_q         <= 5'd0;
         reg_write_wb_q  <= 1'b0;
         valid_wb_q      <= 1'b0;
         access_fault_q  <= 1'b0;
         timeout_fault_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         dmem_req_q      <= dmem_req_d;
         dmem_we_q       <= dmem_we_d;
         dmem_addr_q     <= dmem_addr_d;
         dmem_wdata_q    <= dmem_wdata_d;
         dmem_be_q       <= dmem_be_d;
         f3_q            <= f3_d;
         off_q           <= off_d;
         rd_q            <= rd_d;
         rw_q            <= rw_d;
         wb_sel_q        <= wb_sel_d;
         alu_q           <= alu_d;
         pc4_q           <= pc4_d;
         wb_data_q       <= wb_data_d;
         rd_wb_q         <= rd_wb_d;
         reg_write_wb_q  <= reg_write_wb_d;
         valid_wb_q      <= valid_wb_d;
         access_fault_q  <= access_fault_d;
         timeout_fault_q <= timeout_fault_d;
      end
   end

   assign dmem_req      = dmem_req_q;
   assign dmem_we       = dmem_we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = dmem_wdata_q;
   assign dmem_be       = dmem_be_q;
   assign wb_data_wb    = wb_data_q;
   assign rd_wb         = rd_wb_q;
   assign reg_write_wb  = reg_write_wb_q;
   assign valid_wb      = valid_wb_q;
   assign access_fault  = access_fault_q;
   assign timeout_fault = timeout_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed ops with an arithmetic model of the memory formats
// and a writeback scoreboard compared on every negedge.
module tb_mem_access_stage;

   localparam int W = 38;  // {wb_data[31:0], rd[4:0], reg_write}

   logic        clk, rst_n;
   logic        valid_mem, mem_read_mem, mem_write_mem, reg_write_mem;
   logic [31:0] alu_result_mem, rs2_data_mem, pc_p_4_mem;
   logic [4:0]  rd_mem;
   logic [2:0]  funct3_mem;
   logic [1:0]  wb_sel_mem;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall;
   logic [31:0] wb_data_wb;
   logic [4:0]  rd_wb;
   logic        reg_write_wb, valid_wb, access_fault, timeout_fault;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   int          stall_cnt, req_cnt;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_be;
   logic        seen_we;

   mem_access_stage #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
      .rs2_data_mem(rs2_data_mem), .rd_mem(rd_mem), .pc_p_4_mem(pc_p_4_mem),
      .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .funct3_mem(funct3_mem),
      .reg_write_mem(reg_write_mem), .wb_sel_mem(wb_sel_mem), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .wb_data_wb(wb_data_wb),
      .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .valid_wb(valid_wb),
      .access_fault(access_fault), .timeout_fault(timeout_fault)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // model of the data-memory formats
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int n = size_of(f3);
      int v = ((1 << n) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      int n = size_of(f3);
      logic [31:0] r = 32'h0;
      logic [31:0] sh;
      for (int i = 0; i < 4; i++) begin
         sh = d >> (8 * (i % n));
         r = r | ({24'h0, sh[7:0]} << (8 * i));
      end
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd_word);
      int n = size_of(f3);
      longint unsigned mask = (64'd1 << (8 * n)) - 1;
      longint unsigned v = ({32'h0, rd_word} >> (8 * (a % 4))) & mask;
      if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // driver: present one op, answer the memory, hold until EX/MEM would advance
   task automatic do_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic regw, input logic [1:0] sel,
                        input int ack_after, input logic [31:0] rdata);
      int  busy = 0;
      int  cyc = 0;
      bit  done = 0;
      bit  acked = 0;
      @(negedge clk);
      valid_mem = 1'b1; mem_read_mem = rd_en; mem_write_mem = wr_en; funct3_mem = f3;
      alu_result_mem = alu; rs2_data_mem = rs2; pc_p_4_mem = pc4; rd_mem = rd;
      reg_write_mem = regw; wb_sel_mem = sel; dmem_rdata = rdata;
      stall_cnt = 0; req_cnt = 0;
      while (!done) begin
         dmem_ack = 1'b0;
         #1;
         if (dmem_req) begin
            busy++; req_cnt++;
            if (busy == 1) begin
               seen_addr = dmem_addr; seen_be = dmem_be; seen_wdata = dmem_wdata; seen_we = dmem_we;
            end
            chk("dmem_addr", dmem_addr, alu & ~32'h3);
            chk("dmem_be", dmem_be, m_be(f3, alu));
            chk("dmem_we", dmem_we, wr_en);
            if (wr_en) chk("dmem_wdata", dmem_wdata, m_wdata(f3, rs2));
            if (ack_after >= 0 && busy == ack_after + 1) begin
               dmem_ack = 1'b1;
               acked = 1;
            end
         end
         #1;
         if (stall) stall_cnt++;
         else done = 1;
         if (done) begin
            if (!(rd_en || wr_en))
               exp_q.push_back({(sel == 2'b10) ? pc4 : alu, rd, regw});
            else if (acked)
               exp_q.push_back({wr_en ? ((sel == 2'b10) ? pc4 : alu) : m_load(f3, alu, rdata), rd, regw});
         end
         @(posedge clk);
         cyc++;
         if (!done && cyc > 40) begin
            chk("op cycle budget", 1, 0);
            done = 1;
         end
         if (!done) @(negedge clk);
      end
      #1;
      valid_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0; dmem_ack = 1'b0;
   endtask

   // scoreboard compare on every negedge
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (valid_wb) begin
               if (exp_q.size() == 0) chk("unexpected valid_wb", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("wb_data_wb", wb_data_wb, e[37:6]);
                  chk("rd_wb", rd_wb, e[5:1]);
                  chk("reg_write_wb", reg_write_wb, e[0]);
               end
            end else begin
               chk("reg_write_wb idle", reg_write_wb, 0);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; valid_mem = 0; mem_read_mem = 0; mem_write_mem = 0; reg_write_mem = 0;
      alu_result_mem = 0; rs2_data_mem = 0; pc_p_4_mem = 0; rd_mem = 0; funct3_mem = 0;
      wb_sel_mem = 0; dmem_ack = 0; dmem_rdata = 0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_data_wb, rd_wb,
                            reg_write_wb, valid_wb, access_fault, timeout_fault, stall}, 0);
      rst_n = 1'b1;

      // ALU ops
      do_op(0, 0, 3'b000, 32'h0000_1234, 0, 32'h44, 5'd5, 1, 2'b00, -1, 0);
      chk("alu stall", stall_cnt, 0);
      @(negedge clk);
      chk("alu wb_data", wb_data_wb, 32'h0000_1234);
      chk("alu rd", rd_wb, 5);
      chk("alu valid", valid_wb, 1);
      do_op(0, 0, 3'b000, 32'h0000_0777, 0, 32'h48, 5'd1, 1, 2'b10, -1, 0);
      @(negedge clk);
      chk("link wb_data", wb_data_wb, 32'h0000_0048);
      @(negedge clk);
      chk("bubble valid_wb", valid_wb, 0);
      chk("bubble reg_write_wb", reg_write_wb, 0);

      // LB / LBU with two wait cycles
      do_op(1, 0, 3'b000, 32'h103, 0, 0, 5'd7, 1, 2'b01, 2, 32'h80FF_0000);
      chk("lb addr", seen_addr, 32'h100);
      chk("lb be", seen_be, 4'b1000);
      chk("lb we", seen_we, 0);
      chk("lb stall cycles", stall_cnt, 3);
      chk("lb req cycles", req_cnt, 3);
      @(negedge clk);
      chk("lb data", wb_data_wb, 32'hFFFF_FF80);
      chk("lb valid", valid_wb, 1);
      do_op(1, 0, 3'b100, 32'h103, 0, 0, 5'd8, 1, 2'b01, 2, 32'h80FF_0000);
      @(negedge clk);
      chk("lbu data", wb_data_wb, 32'h0000_0080);

      // SH, immediate ack
      do_op(0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 0, 5'd0, 0, 2'b00, 0, 0);
      chk("sh we", seen_we, 1);
      chk("sh be", seen_be, 4'b1100);
      chk("sh wdata", seen_wdata, 32'hBEEF_BEEF);
      chk("sh addr", seen_addr, 32'h200);
      chk("sh stall cycles", stall_cnt, 1);
      @(negedge clk);
      chk("sh reg_write_wb", reg_write_wb, 0);
      chk("sh valid", valid_wb, 1);

      // faulting accesses
      do_op(1, 0, 3'b010, 32'h101, 0, 0, 5'd9, 1, 2'b01, 0, 32'h1111_1111);
      chk("lw mis req", req_cnt, 0);
      chk("lw mis stall", stall_cnt, 0);
      @(negedge clk);
      chk("lw mis fault", access_fault, 1);
      chk("lw mis valid", valid_wb, 0);
      @(negedge clk);
      chk("fault pulse end", access_fault, 0);
      do_op(1, 0, 3'b011, 32'h100, 0, 0, 5'd9, 1, 2'b01, 0, 32'h1111_1111);
      chk("f3=011 req", req_cnt, 0);
      @(negedge clk);
      chk("f3=011 fault", access_fault, 1);
      chk("f3=011 valid", valid_wb, 0);

      // more formats, back to back
      do_op(1, 0, 3'b001, 32'h102, 0, 0, 5'd10, 1, 2'b01, 0, 32'h8001_1234);
      do_op(1, 0, 3'b101, 32'h100, 0, 0, 5'd11, 1, 2'b01, 0, 32'h8001_1234);
      do_op(0, 1, 3'b000, 32'h201, 32'h0000_0055, 0, 5'd0, 0, 2'b00, 1, 0);
      chk("sb be", seen_be, 4'b0010);
      chk("sb wdata", seen_wdata, 32'h5555_5555);
      do_op(0, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 5'd0, 0, 2'b00, 0, 0);
      chk("sw be", seen_be, 4'b1111);
      do_op(0, 0, 3'b000, 32'h0000_0099, 0, 0, 5'd12, 1, 2'b11, -1, 0);

      // ack in the last allowed cycle beats the timeout
      do_op(1, 0, 3'b010, 32'h208, 0, 0, 5'd13, 1, 2'b01, 3, 32'hDEAD_BEEF);
      chk("late ack stall", stall_cnt, 4);
      chk("late ack req", req_cnt, 4);
      @(negedge clk);
      chk("late ack data", wb_data_wb, 32'hDEAD_BEEF);
      chk("late ack no timeout", timeout_fault, 0);

      // timeout
      do_op(1, 0, 3'b010, 32'h300, 0, 0, 5'd14, 1, 2'b01, -1, 0);
      chk("timeout req", req_cnt, 4);
      chk("timeout stall", stall_cnt, 4);
      @(negedge clk);
      chk("timeout flag", timeout_fault, 1);
      chk("timeout valid", valid_wb, 0);
      do_op(0, 0, 3'b000, 32'h0000_0ABC, 0, 0, 5'd15, 1, 2'b00, -1, 0);
      @(negedge clk);
      chk("post timeout data", wb_data_wb, 32'h0000_0ABC);
      chk("timeout sticky", timeout_fault, 1);

      // reset while BUSY
      @(negedge clk);
      valid_mem = 1; mem_read_mem = 1; funct3_mem = 3'b010; alu_result_mem = 32'h400;
      rd_mem = 5'd16; reg_write_mem = 1; wb_sel_mem = 2'b01; dmem_ack = 0;
      @(negedge clk);
      chk("busy req before reset", dmem_req, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("reset in busy outputs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_data_wb,
                                    rd_wb, reg_write_wb, valid_wb, access_fault, timeout_fault, stall}, 0);
      valid_mem = 0; mem_read_mem = 0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1, 0, 3'b010, 32'h400, 0, 0, 5'd17, 1, 2'b01, 1, 32'h1234_5678);
      chk("post reset stall", stall_cnt, 2);
      @(negedge clk);
      chk("post reset data", wb_data_wb, 32'h1234_5678);
      chk("post reset valid", valid_wb, 1);

      repeat (2) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
